// File: rtl/fc_pkg.sv
// Shared types and constants for the flight-controller rate loops.
// Holds the axis enum, PID sequencer state encoding, Q8.8 gain type and clamp limits.
package fc_pkg;

    typedef enum logic [1:0] {
        ROLL  = 2'd0,
        PITCH = 2'd1,
        YAW   = 2'd2
    } axis_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAP,
        S_P,
        S_I,
        S_D,
        S_SUM,
        S_DONE
    } state_t;

    typedef logic signed [15:0] gain_t;

    localparam int OUT_LIM = 400;
    localparam int INT_LIM = 8000;
    localparam int ACC_W   = 36;
    localparam int OP_W    = 17;

endpackage

// File: rtl/sat_clamp.sv
// Signed saturate-to-(+/-LIM) with optional width reduction.
// Ports: din (IN_W signed) in, dout (OUT_W signed) out; LIM must fit in OUT_W.
module sat_clamp #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16,
    parameter int LIM   = 8000
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [IN_W-1:0] HI = IN_W'(LIM);
    localparam logic signed [IN_W-1:0] LO = IN_W'(-LIM);

    always_comb begin
        if (din > HI) begin
            dout = OUT_W'(HI);
        end else if (din < LO) begin
            dout = OUT_W'(LO);
        end else begin
            dout = OUT_W'(din);
        end
    end

endmodule

// File: rtl/pid_sequencer.sv
// Time-multiplexed roll/pitch/yaw PID using one shared 17x17 multiplier and accumulator.
// Ports: clk, RST (async active-low), enable, err/kp/ki/kd[3] in; net[3], out_valid, busy out.
module pid_sequencer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int FS      = 1000,
    parameter int FRAC    = 8,
    parameter int INT_LIM = fc_pkg::INT_LIM,
    parameter int OUT_LIM = fc_pkg::OUT_LIM
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               enable,
    input  logic signed [15:0] err [3],
    input  logic signed [15:0] kp  [3],
    input  logic signed [15:0] ki  [3],
    input  logic signed [15:0] kd  [3],
    output logic signed [15:0] net [3],
    output logic               out_valid,
    output logic               busy
);

    import fc_pkg::*;

    localparam int DIV   = CLK_HZ / FS;
    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    state_t             state_q, state_d;
    axis_t              axis_q, axis_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [15:0] e_s_q   [3], e_s_d   [3];
    logic signed [15:0] integ_q [3], integ_d [3];
    logic signed [15:0] prev_q  [3], prev_d  [3];
    logic signed [15:0] net_s_q [3], net_s_d [3];
    logic signed [15:0] net_q   [3], net_d   [3];
    logic               out_valid_q, out_valid_d;

    logic signed [OP_W-1:0]   int_sum;
    logic signed [15:0]       int_new;
    logic signed [OP_W-1:0]   diff;
    logic signed [OP_W-1:0]   op_a, op_b;
    logic signed [2*OP_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_shr;
    logic signed [15:0]       res_sat;

    // 17-bit sums cannot wrap for 16-bit operands
    assign int_sum = 17'(integ_q[axis_q]) + 17'(e_s_q[axis_q]);
    assign diff    = 17'(e_s_q[axis_q]) - 17'(prev_q[axis_q]);
    assign acc_shr = acc_q >>> FRAC;

    sat_clamp #(.IN_W(OP_W), .OUT_W(16), .LIM(INT_LIM)) u_int_clamp (
        .din  (int_sum),
        .dout (int_new)
    );

    sat_clamp #(.IN_W(ACC_W), .OUT_W(16), .LIM(OUT_LIM)) u_out_clamp (
        .din  (acc_shr),
        .dout (res_sat)
    );

    // Operand select for the single shared multiplier
    always_comb begin
        op_a = '0;
        op_b = '0;
        unique case (state_q)
            S_P: begin
                op_a = 17'(kp[axis_q]);
                op_b = 17'(e_s_q[axis_q]);
            end
            S_I: begin
                op_a = 17'(ki[axis_q]);
                op_b = 17'(int_new);
            end
            S_D: begin
                op_a = 17'(kd[axis_q]);
                op_b = diff;
            end
            default: ;
        endcase
    end

    assign prod = op_a * op_b;

    always_comb begin
        tick_d      = (cnt_q == CNT_W'(DIV - 1));
        cnt_d       = tick_d ? '0 : cnt_q + 1'b1;
        state_d     = state_q;
        axis_d      = axis_q;
        acc_d       = acc_q;
        e_s_d       = e_s_q;
        integ_d     = integ_q;
        prev_d      = prev_q;
        net_s_d     = net_s_q;
        net_d       = net_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tick_q) state_d = S_CAP;
            end
            S_CAP: begin
                e_s_d   = err;
                axis_d  = ROLL;
                acc_d   = '0;
                state_d = S_P;
            end
            S_P: begin
                acc_d   = acc_q + ACC_W'(prod);
                state_d = S_I;
            end
            S_I: begin
                integ_d[axis_q] = int_new;
                acc_d           = acc_q + ACC_W'(prod);
                state_d         = S_D;
            end
            S_D: begin
                acc_d   = acc_q + ACC_W'(prod);
                state_d = S_SUM;
            end
            S_SUM: begin
                net_s_d[axis_q] = res_sat;
                prev_d[axis_q]  = e_s_q[axis_q];
                acc_d           = '0;
                if (axis_q == YAW) begin
                    // net/out_valid are registered so they appear in DONE
                    net_d       = net_s_d;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    axis_d  = axis_t'(axis_q + 2'd1);
                    state_d = S_P;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Disarmed: abandon any sequence and hold all loop state cleared
        if (!enable) begin
            state_d     = S_IDLE;
            acc_d       = '0;
            integ_d     = '{default: '0};
            prev_d      = '{default: '0};
            net_d       = '{default: '0};
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            state_q     <= S_IDLE;
            axis_q      <= ROLL;
            acc_q       <= '0;
            e_s_q       <= '{default: '0};
            integ_q     <= '{default: '0};
            prev_q      <= '{default: '0};
            net_s_q     <= '{default: '0};
            net_q       <= '{default: '0};
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            state_q     <= state_d;
            axis_q      <= axis_d;
            acc_q       <= acc_d;
            e_s_q       <= e_s_d;
            integ_q     <= integ_d;
            prev_q      <= prev_d;
            net_s_q     <= net_s_d;
            net_q       <= net_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign net       = net_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule
